// File: rtl/lidar_filter_pkg.sv
// Shared types for the lidar radius-outlier path: sequencer FSM states, point record
// and the neighbour-count width helper.
package lidar_filter_pkg;

    localparam int COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } ror_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } point_t;

    function automatic int count_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/point_ring_buffer.sv
// Ring of the last WINDOW accepted points with an occupancy count that saturates at
// WINDOW; the oldest entry is overwritten once full. One asynchronous read port by index.
module point_ring_buffer #(
    parameter int N      = 16,
    parameter int WINDOW = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [3*N-1:0]               wr_data,
    input  logic [$clog2(WINDOW)-1:0]    rd_idx,
    output logic [3*N-1:0]               rd_data,
    output logic [$clog2(WINDOW+1)-1:0]  occupancy
);

    localparam int IW = $clog2(WINDOW);
    localparam int OW = $clog2(WINDOW + 1);

    logic [3*N-1:0] mem_r [WINDOW];
    logic [IW-1:0]  wr_ptr_r;
    logic [OW-1:0]  occ_r;

    // point storage; contents are not cleared, occupancy alone marks valid slots
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // write pointer wraps naturally (WINDOW is a power of two), occupancy saturates
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + IW'(1);
            if (occ_r != OW'(WINDOW)) begin
                occ_r <= occ_r + OW'(1);
            end
        end
    end

    assign rd_data   = mem_r[rd_idx];
    assign occupancy = occ_r;

endmodule

// File: rtl/radius_outlier_sequencer.sv
// Radius-outlier sequencer: streams (candidate, neighbour) pairs to the distance unit and
// counts returned distances within radius. Optional macro EARLY_DECIDE_EN stops issuing once keep is certain.
module radius_outlier_sequencer
    import lidar_filter_pkg::*;
#(
    parameter int N             = 16,
    parameter int WINDOW        = 8,
    parameter int DIST_LATENCY  = 17,
    parameter int MIN_NEIGHBORS = 2,
    parameter int POINT_3D      = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0]                in_x,
    input  logic [N-1:0]                in_y,
    input  logic [N-1:0]                in_z,
    input  logic [N-1:0]                radius,
    output logic [N-1:0]                pair_x1,
    output logic [N-1:0]                pair_y1,
    output logic [N-1:0]                pair_z1,
    output logic [N-1:0]                pair_x2,
    output logic [N-1:0]                pair_y2,
    output logic [N-1:0]                pair_z2,
    input  logic [N-1:0]                dist_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                out_x,
    output logic [N-1:0]                out_y,
    output logic [N-1:0]                out_z,
    output logic                        out_keep,
    output logic [$clog2(WINDOW+1)-1:0] out_count
);

    localparam int IW = $clog2(WINDOW);
    localparam int CW = count_width(WINDOW);
    localparam int L  = DIST_LATENCY;
    localparam logic [CW-1:0] WIN_C = CW'(WINDOW);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_NEIGHBORS);

    ror_state_t      state_r, state_nxt_s;
    logic [3*N-1:0]  cand_r, cand_src_s, rd_data_s;
    logic [N-1:0]    radius_r;
    logic [IW-1:0]   rd_idx_r, rd_sel_s;
    logic [CW-1:0]   count_r, count_nxt_s, fin_count_s, occ_s;
    logic [L-1:0]    tag_r;
    logic            accept_s, out_hs_s, issue_s, load_pair_s, out_load_s;
    logic            last_s, early_s, drain_done_s, inc_s;

    assign accept_s     = in_valid & in_ready;
    assign out_hs_s     = out_valid & out_ready;
    assign last_s       = (CW'(rd_idx_r) == (occ_s - CW'(1)));
    assign drain_done_s = (tag_r[L-2:0] == '0);
    assign inc_s        = tag_r[L-1] & (dist_in <= radius_r);
    assign count_nxt_s  = (inc_s && (count_r != WIN_C)) ? (count_r + CW'(1)) : count_r;
    assign cand_src_s   = accept_s ? {in_x, in_y, in_z} : cand_r;
`ifdef EARLY_DECIDE_EN
    assign early_s      = (count_r >= MIN_C);
`else
    assign early_s      = 1'b0;
`endif

    point_ring_buffer #(.N(N), .WINDOW(WINDOW)) u_ring (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (out_hs_s),
        .wr_data   ({out_x, out_y, out_z}),
        .rd_idx    (rd_sel_s),
        .rd_data   (rd_data_s),
        .occupancy (occ_s)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (accept_s) state_nxt_s = (occ_s == '0) ? OUTPUT : ISSUE;
                     else          state_nxt_s = IDLE;
            ISSUE:   if (last_s || early_s) state_nxt_s = DRAIN;
                     else                   state_nxt_s = ISSUE;
            DRAIN:   if (drain_done_s) state_nxt_s = OUTPUT;
                     else              state_nxt_s = DRAIN;
            OUTPUT:  if (out_hs_s) state_nxt_s = IDLE;
                     else          state_nxt_s = OUTPUT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs; the pair register is loaded one cycle ahead so each ISSUE cycle presents one pair
    always_comb begin
        issue_s     = (state_r == ISSUE);
        load_pair_s = 1'b0;
        rd_sel_s    = '0;
        fin_count_s = count_nxt_s;
        out_load_s  = (state_r != OUTPUT) && (state_nxt_s == OUTPUT);
        case (state_r)
            IDLE: begin
                load_pair_s = accept_s && (occ_s != '0);
                rd_sel_s    = '0;
                fin_count_s = '0;
            end
            ISSUE: begin
                load_pair_s = !(last_s || early_s);
                rd_sel_s    = rd_idx_r + IW'(1);
            end
            default: begin
                load_pair_s = 1'b0;
                rd_sel_s    = '0;
            end
        endcase
    end

    // candidate latch, read index, neighbour counter and tag pipe
    always_ff @(posedge clock) begin
        if (reset) begin
            cand_r   <= '0;
            radius_r <= '0;
            rd_idx_r <= '0;
            count_r  <= '0;
            tag_r    <= '0;
        end else begin
            tag_r <= {tag_r[L-2:0], issue_s};
            if (accept_s) begin
                cand_r   <= {in_x, in_y, in_z};
                radius_r <= radius;
                rd_idx_r <= '0;
                count_r  <= '0;
            end else begin
                count_r <= count_nxt_s;
                if (load_pair_s) begin
                    rd_idx_r <= rd_idx_r + IW'(1);
                end
            end
        end
    end

    // pair registers towards the distance unit
    always_ff @(posedge clock) begin
        if (reset) begin
            {pair_x1, pair_y1, pair_z1} <= '0;
            {pair_x2, pair_y2, pair_z2} <= '0;
        end else if (load_pair_s) begin
            pair_x1 <= cand_src_s[3*N-1:2*N];
            pair_y1 <= cand_src_s[2*N-1:N];
            pair_z1 <= (POINT_3D != 0) ? cand_src_s[N-1:0] : '0;
            pair_x2 <= rd_data_s[3*N-1:2*N];
            pair_y2 <= rd_data_s[2*N-1:N];
            pair_z2 <= (POINT_3D != 0) ? rd_data_s[N-1:0] : '0;
        end
    end

    // registered result and handshake flags
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_keep  <= 1'b0;
            out_count <= '0;
            {out_x, out_y, out_z} <= '0;
        end else begin
            in_ready <= (state_nxt_s == IDLE);
            if (out_load_s) begin
                out_valid <= 1'b1;
                {out_x, out_y, out_z} <= cand_src_s;
                out_count <= fin_count_s;
                out_keep  <= (fin_count_s >= MIN_C);
            end else if (out_hs_s) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
